dsha_nonce_scheduler: RTL and testbench
=======================================

Name: dsha_nonce_scheduler

Overview:
- Sequences a single shared SHA-256 compression core through the Bitcoin double-hash for a nonce range.
- Per job, computes the header midstate once. Per nonce, it issues block 2 (header tail, nonce and padding) and block 3 (first digest with 256-bit-length padding), then compares the result to a target.
- Sits between the job-dispatch logic and the compression core. Reports the first winning nonce, or exhaustion of the range.

Parameters:
- REPORT_ALL, 0: when 1, emits a result for every nonce (res_found indicates a pass); when 0, emits only on first pass or on exhaustion.
- CORE_TIMEOUT, 1023: cycles to wait for core_done before raising res_error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler idle, accepts job
- job_header  in  608  header bytes 0..75; byte 0 at [607:600]
- job_nonce_start  in  32  first nonce, inclusive
- job_nonce_end  in  32  last nonce, inclusive
- job_target  in  256  pass threshold
- abort  in  1  cancel current job
- core_start  out  1  one-cycle compression request
- core_block  out  512  message block
- core_chain  out  256  input chaining value
- core_done  in  1  one-cycle completion pulse
- core_digest  in  256  output chaining value, valid with core_done
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_found  out  1  hash passed target
- res_error  out  1  core timeout
- res_nonce  out  32  nonce of the result
- res_hash  out  256  final digest, raw core byte order

Behaviour:
- Reset is synchronous and active-high on clock clk.
- Reset values: all outputs 0. FSM goes to IDLE. job_ready becomes 1 on the first cycle after reset deasserts.
- Reset asserted mid-operation abandons the job immediately; any later core_done is ignored.
- States: IDLE, MID_REQ, MID_WAIT, B2_REQ, B2_WAIT, B3_REQ, B3_WAIT, CHECK, REPORT, DRAIN.
- IDLE: job_ready=1. On job_valid, capture the header, range and target, set nonce=job_nonce_start, and go to MID_REQ. job_ready drops the same cycle.
- MID_REQ: core_block = header bytes 0..63; core_chain = SHA-256 IV (6a09e667 ... 5be0cd19); core_start=1 for exactly one cycle. Go to MID_WAIT.
- MID_WAIT: on core_done, register the midstate. Go to B2_REQ.
- B2_REQ/B2_WAIT: core_chain=midstate. core_block = {header bytes 64..75, nonce byte-swapped (little-endian), 8'h80, 312'b0, 64'd640}. On core_done, register digest1.
- B3_REQ/B3_WAIT: core_chain=IV. core_block = {digest1, 8'h80, 184'b0, 64'd256}. On core_done, register the hash.
- core_block and core_chain are held stable from core_start until core_done.
- core_done arriving in any non-WAIT state is ignored.
- CHECK:
  - pass = (byte-reversed hash, as an unsigned 256-bit value) <= job_target.
  - Go to REPORT if pass, if nonce==job_nonce_end, or if REPORT_ALL=1.
  - Otherwise nonce <= nonce+1 (mod 2^32) and go to B2_REQ. The midstate is not recomputed.
  - CHECK takes 1 cycle.
- REPORT:
  - res_valid=1 with res_found, res_nonce and res_hash held stable until res_ready.
  - If res_ready=1 is already high on the cycle res_valid first rises, the transfer completes that cycle.
  - After the transfer: go to IDLE if pass, nonce==end, or error; otherwise (REPORT_ALL only) increment nonce and go to B2_REQ.
- Range rules:
  - start==end: exactly one nonce.
  - end<start: the sweep wraps through FFFFFFFF to 0 and stops after end.
  - start=0, end=FFFFFFFF: full 2^32 sweep, no early termination except on a pass.
- Abort:
  - In a *_REQ or CHECK state: go to IDLE next cycle.
  - In a *_WAIT state: go to DRAIN, wait for core_done, then IDLE.
  - In REPORT: drop res_valid and go to IDLE.
  - No result is emitted after an abort.
- Timeout: a counter runs in *_WAIT states. When it reaches CORE_TIMEOUT, go to REPORT with res_error=1, res_found=0 and the current nonce, then IDLE.
- Latency per nonce = 2 core latencies + 5 cycles. Midstate adds 1 core latency + 2 cycles once per job.

Test Plan:
- Genesis header (version 1, merkle 4a5e1e4b..., time 495fab29, bits 1d00ffff), nonce range 7c2bac1d..7c2bac1d, target 00000000ffff0000...0 -> exactly 3 core_start pulses; res_found=1, res_nonce=7c2bac1d; res_hash byte-reversed = 000000000019d6689c085ae165831e93...
- Same header, range 7c2bac1b..7c2bac20 -> 1 midstate plus 3×2 nonce compressions; res_found=1 at 7c2bac1d; no further core_start; job_ready returns 1.
- Same header, range 0..3, target 0 -> four nonce passes; single result with res_found=0, res_nonce=3.
- Wrap: range FFFFFFFE..00000001, target 0, REPORT_ALL=1 -> four results with nonces FFFFFFFE, FFFFFFFF, 0, 1, all res_found=0; res_ready held low 5 cycles on the second result -> outputs stable, no core activity during the stall.
- abort asserted during B3_WAIT -> core_start stays 0, the FSM waits for the pending core_done, no res_valid, job_ready=1 one cycle after core_done; reset asserted in B2_WAIT -> all outputs 0 next cycle.
- Mock core that never returns core_done, CORE_TIMEOUT=15 -> res_valid with res_error=1 sixteen cycles after core_start; then IDLE.

Source files
------------

// File: rtl/dsha_nonce_scheduler.sv
// Drives one shared SHA-256 compression core through the Bitcoin double hash
// for each nonce of a job's range, and reports the first winner or range exhaustion.
module dsha_nonce_scheduler #(
  parameter int REPORT_ALL   = 0,
  parameter int CORE_TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [607:0] job_header,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_chain,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic         res_error,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash
);

  typedef enum logic [3:0] {
    IDLE, MID_REQ, MID_WAIT, B2_REQ, B2_WAIT, B3_REQ, B3_WAIT, CHECK, REPORT, DRAIN
  } state_t;

  localparam logic [255:0] SHA_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] TMO_LAST = 32'(CORE_TIMEOUT - 1);
  localparam bit TMO_EN  = (CORE_TIMEOUT != 0);
  localparam bit RPT_ALL = (REPORT_ALL != 0);

  state_t         state, state_nxt;
  logic [1:0]     phase;
  logic [31:0]    tmo_cnt;
  logic           pass_q, err_q;
  logic [607:0]   hdr;
  logic [31:0]    nonce, nonce_end;
  logic [255:0]   target, midstate, digest1, hash;
  logic           pass, last, in_wait, tmo_hit, nonce_inc, set_err;
  logic [31:0]    nonce_le;
  logic [511:0]   blk2, blk3;

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
    return r;
  endfunction

  assign pass     = (bswap256(hash) <= target);
  assign last     = (nonce == nonce_end);
  assign in_wait  = (state == MID_WAIT) || (state == B2_WAIT) || (state == B3_WAIT);
  assign tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
  assign nonce_le = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
  assign blk2     = {hdr[95:0], nonce_le, 8'h80, 312'b0, 64'd640};
  assign blk3     = {digest1, 8'h80, 184'b0, 64'd256};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control registers; DRAIN keeps counting so a dead core cannot wedge an abort
  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= 2'd0;
      tmo_cnt <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (in_wait || state == DRAIN) ? tmo_cnt + 1 : '0;
      if (state == IDLE && job_valid) begin
        pass_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (state == CHECK) pass_q <= pass;
      if (set_err)        err_q  <= 1'b1;
      case (state_nxt)
        MID_REQ: phase <= 2'd0;
        B2_REQ:  phase <= 2'd1;
        B3_REQ:  phase <= 2'd2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && job_valid) begin
      hdr       <= job_header;
      nonce     <= job_nonce_start;
      nonce_end <= job_nonce_end;
      target    <= job_target;
    end
    if (nonce_inc) nonce <= nonce + 1;
    if (core_done) begin
      case (state)
        MID_WAIT: midstate <= core_digest;
        B2_WAIT:  digest1  <= core_digest;
        B3_WAIT:  hash     <= core_digest;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    nonce_inc = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE:    if (job_valid) state_nxt = MID_REQ;
      MID_REQ: state_nxt = abort ? IDLE : MID_WAIT;
      B2_REQ:  state_nxt = abort ? IDLE : B2_WAIT;
      B3_REQ:  state_nxt = abort ? IDLE : B3_WAIT;
      MID_WAIT, B2_WAIT, B3_WAIT: begin
        if (core_done) begin
          if (abort)                 state_nxt = IDLE;
          else if (state == MID_WAIT) state_nxt = B2_REQ;
          else if (state == B2_WAIT)  state_nxt = B3_REQ;
          else                        state_nxt = CHECK;
        end else if (abort) begin
          state_nxt = DRAIN;
        end else if (tmo_hit) begin
          state_nxt = REPORT;
          set_err   = 1'b1;
        end
      end
      CHECK: begin
        if (abort)                       state_nxt = IDLE;
        else if (pass || last || RPT_ALL) state_nxt = REPORT;
        else begin
          nonce_inc = 1'b1;
          state_nxt = B2_REQ;
        end
      end
      REPORT: begin
        if (abort) state_nxt = IDLE;
        else if (res_ready) begin
          if (pass_q || err_q || last) state_nxt = IDLE;
          else begin
            nonce_inc = 1'b1;
            state_nxt = B2_REQ;
          end
        end
      end
      DRAIN:   if (core_done || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_ready  = 1'b0;
    core_start = 1'b0;
    core_block = '0;
    core_chain = '0;
    res_valid  = 1'b0;
    res_found  = 1'b0;
    res_error  = 1'b0;
    res_nonce  = '0;
    res_hash   = '0;
    if (!reset) begin
      case (state)
        IDLE:                    job_ready  = 1'b1;
        MID_REQ, B2_REQ, B3_REQ: core_start = 1'b1;
        REPORT: begin
          res_valid = 1'b1;
          res_found = pass_q & ~err_q;
          res_error = err_q;
          res_nonce = nonce;
          res_hash  = hash;
        end
        default: ;
      endcase
      if (state != IDLE && state != CHECK && state != REPORT) begin
        case (phase)
          2'd0: begin
            core_block = hdr[607:96];
            core_chain = SHA_IV;
          end
          2'd1: begin
            core_block = blk2;
            core_chain = midstate;
          end
          default: begin
            core_block = blk3;
            core_chain = SHA_IV;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsha_nonce_scheduler.sv
// Directed bench: two scheduler instances (first-hit and report-all) each served
// by a behavioural SHA-256 compression core with fixed latency.
module tb_dsha_nonce_scheduler;

  localparam int LAT = 4;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [607:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_REV =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] GEN_TGT = {32'h0, 16'hffff, 208'h0};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid [2];
  logic         job_ready [2];
  logic [607:0] job_header [2];
  logic [31:0]  job_nonce_start [2];
  logic [31:0]  job_nonce_end [2];
  logic [255:0] job_target [2];
  logic         abort [2];
  logic         core_start [2];
  logic [511:0] core_block [2];
  logic [255:0] core_chain [2];
  logic         core_done [2] = '{1'b0, 1'b0};
  logic [255:0] core_digest [2] = '{256'h0, 256'h0};
  logic         res_valid [2];
  logic         res_ready [2];
  logic         res_found [2];
  logic         res_error [2];
  logic [31:0]  res_nonce [2];
  logic [255:0] res_hash [2];

  logic         pend [2] = '{1'b0, 1'b0};
  int           cnt [2] = '{0, 0};
  logic [511:0] blk_s [2];
  logic [255:0] chn_s [2];
  logic         mute [2];
  int           starts [2] = '{0, 0};
  int           unstable [2] = '{0, 0};

  int n_chk = 0;
  int n_pass = 0;
  int s0, s1, k;
  bit bad;
  logic [31:0] wr [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};

  always #5 clk = ~clk;

  dsha_nonce_scheduler #(.REPORT_ALL(0), .CORE_TIMEOUT(15)) u_dut0 (
    .clk(clk), .reset(reset), .job_valid(job_valid[0]), .job_ready(job_ready[0]),
    .job_header(job_header[0]), .job_nonce_start(job_nonce_start[0]),
    .job_nonce_end(job_nonce_end[0]), .job_target(job_target[0]), .abort(abort[0]),
    .core_start(core_start[0]), .core_block(core_block[0]), .core_chain(core_chain[0]),
    .core_done(core_done[0]), .core_digest(core_digest[0]), .res_valid(res_valid[0]),
    .res_ready(res_ready[0]), .res_found(res_found[0]), .res_error(res_error[0]),
    .res_nonce(res_nonce[0]), .res_hash(res_hash[0]));

  dsha_nonce_scheduler #(.REPORT_ALL(1)) u_dut1 (
    .clk(clk), .reset(reset), .job_valid(job_valid[1]), .job_ready(job_ready[1]),
    .job_header(job_header[1]), .job_nonce_start(job_nonce_start[1]),
    .job_nonce_end(job_nonce_end[1]), .job_target(job_target[1]), .abort(abort[1]),
    .core_start(core_start[1]), .core_block(core_block[1]), .core_chain(core_chain[1]),
    .core_done(core_done[1]), .core_digest(core_digest[1]), .res_valid(res_valid[1]),
    .res_ready(res_ready[1]), .res_found(res_found[1]), .res_error(res_error[1]),
    .res_nonce(res_nonce[1]), .res_hash(res_hash[1]));

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_cmp(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [255:0] dsha(input logic [607:0] h, input logic [31:0] n);
    logic [255:0] mid, d1;
    mid = sha_cmp(IV, h[607:96]);
    d1  = sha_cmp(mid, {h[95:0], n[7:0], n[15:8], n[23:16], n[31:24], 8'h80, 312'b0, 64'd640});
    return sha_cmp(IV, {d1, 8'h80, 184'b0, 64'd256});
  endfunction

  // Behavioural compression core: LAT cycles after core_start, one done pulse
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      core_done[i] <= 1'b0;
      if (core_start[i]) begin
        starts[i] <= starts[i] + 1;
        if (!mute[i]) begin
          pend[i]  <= 1'b1;
          cnt[i]   <= LAT - 1;
          blk_s[i] <= core_block[i];
          chn_s[i] <= core_chain[i];
        end
      end else if (pend[i]) begin
        if (core_block[i] !== blk_s[i] || core_chain[i] !== chn_s[i]) unstable[i] <= unstable[i] + 1;
        if (cnt[i] == 0) begin
          pend[i]        <= 1'b0;
          core_done[i]   <= 1'b1;
          core_digest[i] <= sha_cmp(chn_s[i], blk_s[i]);
        end else begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic submit(input int d, input logic [607:0] h, input logic [31:0] s,
                        input logic [31:0] e, input logic [255:0] t);
    @(negedge clk);
    check("job_ready_before_submit", 256'(job_ready[d]), 256'(1));
    job_valid[d] = 1'b1; job_header[d] = h; job_nonce_start[d] = s;
    job_nonce_end[d] = e; job_target[d] = t;
    @(negedge clk);
    job_valid[d] = 1'b0;
  endtask

  task automatic wait_res(input int d, input string tag);
    int n;
    n = 0;
    while (!res_valid[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(res_valid[d]), 256'(1));
  endtask

  task automatic wait_starts(input int d, input int base, input int want, input string tag);
    int n;
    n = 0;
    while ((starts[d] - base) < want && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(starts[d] - base), 256'(want));
  endtask

  task automatic accept(input int d);
    res_ready[d] = 1'b1;
    @(negedge clk);
    res_ready[d] = 1'b0;
  endtask

  task automatic single_genesis(input logic [255:0] t, input logic exp_found, input string tag);
    s0 = starts[0];
    submit(0, GEN_HDR, 32'h7c2bac1d, 32'h7c2bac1d, t);
    wait_res(0, {tag, "_valid"});
    check({tag, "_found"}, 256'(res_found[0]), 256'(exp_found));
    check({tag, "_nonce"}, 256'(res_nonce[0]), 256'(32'h7c2bac1d));
    check({tag, "_hash"}, res_hash[0], GEN_HASH);
    check({tag, "_error"}, 256'(res_error[0]), 256'(0));
    check({tag, "_starts"}, 256'(starts[0] - s0), 256'(3));
    accept(0);
    repeat (4) @(negedge clk);
    check({tag, "_idle"}, 256'(job_ready[0]), 256'(1));
    check({tag, "_no_more_starts"}, 256'(starts[0] - s0), 256'(3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      job_valid[i] = 1'b0; job_header[i] = '0; job_nonce_start[i] = '0; job_nonce_end[i] = '0;
      job_target[i] = '0; abort[i] = 1'b0; res_ready[i] = 1'b0; mute[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_job_ready", 256'(job_ready[0]), 256'(0));
    check("rst_res_valid", 256'(res_valid[0]), 256'(0));
    check("rst_core_start", 256'(core_start[0]), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready0", 256'(job_ready[0]), 256'(1));
    check("post_rst_ready1", 256'(job_ready[1]), 256'(1));

    single_genesis(GEN_TGT, 1'b1, "t1_genesis");
    single_genesis(GEN_REV, 1'b1, "t1_target_equal");
    single_genesis(GEN_REV - 256'd1, 1'b0, "t1_target_below");

    s0 = starts[0];
    submit(0, GEN_HDR, 32'h7c2bac1b, 32'h7c2bac20, GEN_TGT);
    wait_res(0, "t2_valid");
    check("t2_found", 256'(res_found[0]), 256'(1));
    check("t2_nonce", 256'(res_nonce[0]), 256'(32'h7c2bac1d));
    check("t2_starts", 256'(starts[0] - s0), 256'(7));
    accept(0);
    repeat (10) @(negedge clk);
    check("t2_no_more_starts", 256'(starts[0] - s0), 256'(7));
    check("t2_idle", 256'(job_ready[0]), 256'(1));
    check("t2_core_stable", 256'(unstable[0]), 256'(0));

    s0 = starts[0];
    res_ready[0] = 1'b1;
    submit(0, GEN_HDR, 32'h0, 32'h3, 256'h0);
    wait_res(0, "t3_valid");
    check("t3_found", 256'(res_found[0]), 256'(0));
    check("t3_nonce", 256'(res_nonce[0]), 256'(3));
    check("t3_starts", 256'(starts[0] - s0), 256'(9));
    @(negedge clk);
    check("t3_same_cycle_xfer", 256'(res_valid[0]), 256'(0));
    check("t3_idle", 256'(job_ready[0]), 256'(1));
    res_ready[0] = 1'b0;

    s0 = starts[1];
    submit(1, GEN_HDR, 32'hFFFFFFFE, 32'h1, 256'h0);
    for (int r = 0; r < 4; r++) begin
      wait_res(1, "t4_valid");
      check("t4_nonce", 256'(res_nonce[1]), 256'(wr[r]));
      check("t4_found", 256'(res_found[1]), 256'(0));
      check("t4_hash", res_hash[1], dsha(GEN_HDR, wr[r]));
      if (r == 1) begin
        s1 = starts[1];
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("t4_stall_valid", 256'(res_valid[1]), 256'(1));
          check("t4_stall_nonce", 256'(res_nonce[1]), 256'(32'hFFFFFFFF));
          check("t4_stall_hash", res_hash[1], dsha(GEN_HDR, 32'hFFFFFFFF));
          check("t4_stall_core", 256'(starts[1] - s1), 256'(0));
        end
      end
      accept(1);
    end
    repeat (3) @(negedge clk);
    check("t4_idle", 256'(job_ready[1]), 256'(1));
    check("t4_starts", 256'(starts[1] - s0), 256'(9));
    check("t4_core_stable", 256'(unstable[1]), 256'(0));

    s0 = starts[0];
    submit(0, GEN_HDR, 32'h0, 32'h0, 256'h0);
    wait_starts(0, s0, 3, "t5_reach_b3");
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    bad = 1'b0;
    k = 0;
    while (!core_done[0] && k < 50) begin
      if (core_start[0] || res_valid[0] || job_ready[0]) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check("t5_done_seen", 256'(core_done[0]), 256'(1));
    check("t5_quiet_drain", 256'(bad), 256'(0));
    check("t5_ready_in_drain", 256'(job_ready[0]), 256'(0));
    @(negedge clk);
    check("t5_ready_after_done", 256'(job_ready[0]), 256'(1));
    check("t5_no_result", 256'(res_valid[0]), 256'(0));
    check("t5_starts", 256'(starts[0] - s0), 256'(3));

    s0 = starts[0];
    submit(0, GEN_HDR, 32'h0, 32'h0, 256'h0);
    wait_starts(0, s0, 2, "t6_reach_b2");
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", 256'(job_ready[0]), 256'(0));
    check("t6_rst_start", 256'(core_start[0]), 256'(0));
    check("t6_rst_block", core_block[0][255:0] | core_block[0][511:256], 256'h0);
    check("t6_rst_chain", core_chain[0], 256'h0);
    check("t6_rst_res", 256'(res_valid[0]), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after_rst", 256'(job_ready[0]), 256'(1));
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (core_start[0] || res_valid[0] || !job_ready[0]) bad = 1'b1;
    end
    check("t6_late_done_ignored", 256'(bad), 256'(0));
    check("t6_starts", 256'(starts[0] - s0), 256'(2));

    mute[0] = 1'b1;
    submit(0, GEN_HDR, 32'h12345678, 32'h12345680, GEN_TGT);
    check("t7_start_seen", 256'(core_start[0]), 256'(1));
    k = 0;
    while (!res_valid[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t7_timeout_cycles", 256'(k), 256'(16));
    check("t7_error", 256'(res_error[0]), 256'(1));
    check("t7_found", 256'(res_found[0]), 256'(0));
    check("t7_nonce", 256'(res_nonce[0]), 256'(32'h12345678));
    accept(0);
    check("t7_idle", 256'(job_ready[0]), 256'(1));
    mute[0] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
